// File: rtl/ofmap_pkg.sv
// Shared types and widths for the output-feature-map buffer writer.
// One 128-bit buffer word holds sixteen 8-bit MAC results, lane 0 in the low byte.
package ofmap_pkg;

  localparam int LANES      = 16;
  localparam int LANE_W     = 8;
  localparam int WORD_W     = LANES * LANE_W;
  localparam int ADDR_W     = 9;
  localparam int LANE_IDX_W = 4;
  localparam int CNT_W      = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ofmap_pack16.sv
// Sixteen-lane byte packer: collects bytes into one buffer word and tracks filled lanes.
// merged_word shows the word including the byte being pushed this cycle, so a full word can be written without a bubble.
module ofmap_pack16
  import ofmap_pkg::*;
(
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  clear,
  input  logic                  push,
  input  logic [LANE_IDX_W-1:0] lane,
  input  logic [LANE_W-1:0]     data,
  output logic [WORD_W-1:0]     word,
  output logic [LANES-1:0]      mask,
  output logic [WORD_W-1:0]     merged_word
);

  logic [LANES-1:0] merged_mask;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic hit;
      assign hit = push && (lane == LANE_IDX_W'(gi));
      assign merged_word[gi*LANE_W +: LANE_W] = hit ? data : word[gi*LANE_W +: LANE_W];
      assign merged_mask[gi] = mask[gi] | hit;
    end
  endgenerate

  // A completed word leaves through merged_word, so the register restarts empty.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      word <= '0;
      mask <= '0;
    end else if (push) begin
      if (lane == LANE_IDX_W'(LANES - 1)) begin
        word <= '0;
        mask <= '0;
      end else begin
        word <= merged_word;
        mask <= merged_mask;
      end
    end
  end

endmodule

// File: rtl/ofmap_writer.sv
// Writes a frame of MAC result bytes into a 16-bank byte-wide buffer, one 128-bit word per 16 bytes.
// A trailing partial word is flushed with byte enables for the filled lanes only.
module ofmap_writer
  import ofmap_pkg::*;
#(
  parameter int                FRAME_PIX = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 9'd0
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               iStart,
  input  logic               iVld,
  input  logic [LANE_W-1:0]  iData,
  output logic [LANES-1:0]   o_ena,
  output logic [ADDR_W-1:0]  o_addra,
  output logic [LANES-1:0]   o_wea,
  output logic [WORD_W-1:0]  o_dia,
  output logic               oBusy,
  output logic               oDone,
  output logic               oDrop
);

  localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(FRAME_PIX);
  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

  state_t                  state;
  logic [CNT_W-1:0]        pix_cnt;
  logic [CNT_W-1:0]        pix_next;
  logic [ADDR_W-1:0]       addr;
  logic [LANE_IDX_W-1:0]   lane;
  logic                    pack_clear;
  logic                    pack_push;
  logic [WORD_W-1:0]       pack_word;
  logic [LANES-1:0]        pack_mask;
  logic [WORD_W-1:0]       merged_word;

  assign lane       = pix_cnt[LANE_IDX_W-1:0];
  assign pix_next   = pix_cnt + CNT_W'(1);
  assign pack_clear = (state == ST_IDLE) && iStart;
  assign pack_push  = (state == ST_RUN) && iVld;

  ofmap_pack16 u_pack (
    .clk         (clk),
    .srst        (rstn),
    .clear       (pack_clear),
    .push        (pack_push),
    .lane        (lane),
    .data        (iData),
    .word        (pack_word),
    .mask        (pack_mask),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state   <= ST_IDLE;
      pix_cnt <= '0;
      addr    <= BASE_ADDR;
      o_ena   <= '0;
      o_wea   <= '0;
      o_addra <= '0;
      o_dia   <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oDrop   <= 1'b0;
    end else begin
      o_ena <= '0;
      o_wea <= '0;
      oDone <= 1'b0;
      // Bytes arriving outside RUN (including alongside iStart) are lost.
      if (iVld && (state != ST_RUN)) oDrop <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (iStart) begin
            state   <= ST_RUN;
            pix_cnt <= '0;
            addr    <= BASE_ADDR;
            oBusy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (iVld) begin
            pix_cnt <= pix_next;
            if (lane == LAST_LANE) begin
              o_ena   <= '1;
              o_wea   <= '1;
              o_dia   <= merged_word;
              o_addra <= addr;
              addr    <= addr + ADDR_W'(1);
            end
            if (pix_next == LAST_CNT) begin
              state <= (lane == LAST_LANE) ? ST_DONE : ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          o_ena   <= '1;
          o_wea   <= pack_mask;
          o_dia   <= pack_word;
          o_addra <= addr;
          addr    <= addr + ADDR_W'(1);
          state   <= ST_DONE;
        end
        ST_DONE: begin
          oDone <= 1'b1;
          oBusy <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed bench for ofmap_writer: four instances with different frame sizes share one stimulus stream.
// A negedge monitor logs every buffer write and done pulse per instance.
module tb_ofmap_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn;
  logic         iStart;
  logic         iVld;
  logic [7:0]   iData;

  logic [15:0]  ena   [4];
  logic [8:0]   addra [4];
  logic [15:0]  wea   [4];
  logic [127:0] dia   [4];
  logic         busy  [4];
  logic         done  [4];
  logic         drop  [4];

  ofmap_writer #(.FRAME_PIX(32), .BASE_ADDR(9'd0)) u_f32 (
    .clk(clk), .rstn(rstn), .iStart(iStart), .iVld(iVld), .iData(iData),
    .o_ena(ena[0]), .o_addra(addra[0]), .o_wea(wea[0]), .o_dia(dia[0]),
    .oBusy(busy[0]), .oDone(done[0]), .oDrop(drop[0]));

  ofmap_writer #(.FRAME_PIX(20), .BASE_ADDR(9'd0)) u_f20 (
    .clk(clk), .rstn(rstn), .iStart(iStart), .iVld(iVld), .iData(iData),
    .o_ena(ena[1]), .o_addra(addra[1]), .o_wea(wea[1]), .o_dia(dia[1]),
    .oBusy(busy[1]), .oDone(done[1]), .oDrop(drop[1]));

  ofmap_writer #(.FRAME_PIX(16), .BASE_ADDR(9'd0)) u_f16 (
    .clk(clk), .rstn(rstn), .iStart(iStart), .iVld(iVld), .iData(iData),
    .o_ena(ena[2]), .o_addra(addra[2]), .o_wea(wea[2]), .o_dia(dia[2]),
    .oBusy(busy[2]), .oDone(done[2]), .oDrop(drop[2]));

  ofmap_writer #(.FRAME_PIX(48), .BASE_ADDR(9'd510)) u_f48 (
    .clk(clk), .rstn(rstn), .iStart(iStart), .iVld(iVld), .iData(iData),
    .o_ena(ena[3]), .o_addra(addra[3]), .o_wea(wea[3]), .o_dia(dia[3]),
    .oBusy(busy[3]), .oDone(done[3]), .oDrop(drop[3]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int           wr_cnt   [4];
  logic [8:0]   wr_addr  [4][8];
  logic [127:0] wr_data  [4][8];
  logic [15:0]  wr_wea   [4][8];
  logic [15:0]  wr_ena   [4][8];
  int           wr_cyc   [4][8];
  int           done_cnt [4];
  int           done_cyc [4];
  logic         busy_at_done [4];

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ena[i] != 16'h0) begin
        if (wr_cnt[i] < 8) begin
          wr_addr[i][wr_cnt[i]] = addra[i];
          wr_data[i][wr_cnt[i]] = dia[i];
          wr_wea[i][wr_cnt[i]]  = wea[i];
          wr_ena[i][wr_cnt[i]]  = ena[i];
          wr_cyc[i][wr_cnt[i]]  = cyc;
        end
        wr_cnt[i] = wr_cnt[i] + 1;
      end
      if (done[i]) begin
        done_cnt[i]     = done_cnt[i] + 1;
        done_cyc[i]     = cyc;
        busy_at_done[i] = busy[i];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int last_acc;
  int acc16;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) begin
      wr_cnt[i]   = 0;
      done_cnt[i] = 0;
      done_cyc[i] = 0;
      busy_at_done[i] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b1; iStart = 1'b0; iVld = 1'b0; iData = 8'h00;
    tick(); tick();
    rstn = 1'b0;
    clear_logs();
  endtask

  task automatic start();
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    iVld = 1'b1; iData = d;
    tick();
    iVld = 1'b0;
    last_acc = cyc;
  endtask

  task automatic wait_done(input int idx);
    for (int n = 0; n < 20; n++) begin
      if (done_cnt[idx] != 0) break;
      tick();
    end
    tick(); tick();
  endtask

  initial begin
    rstn = 1'b1; iStart = 1'b0; iVld = 1'b0; iData = 8'h00;
    clear_logs();

    // Reset state
    do_reset();
    check("rst_ena",   128'(ena[3]),   128'h0);
    check("rst_wea",   128'(wea[3]),   128'h0);
    check("rst_addra", 128'(addra[3]), 128'h0);
    check("rst_dia",   dia[3],         128'h0);
    check("rst_busy",  128'(busy[3]),  128'h0);
    check("rst_done",  128'(done[3]),  128'h0);
    check("rst_drop",  128'(drop[3]),  128'h0);

    // 32 back-to-back bytes, with a stray iStart mid-frame that must be ignored
    start();
    check("f32_busy", 128'(busy[0]), 128'h1);
    for (int k = 0; k < 32; k++) begin
      iStart = (k == 5);
      send_byte(8'(k));
      iStart = 1'b0;
      if (k == 15) acc16 = last_acc;
    end
    wait_done(0);
    check("f32_wr_cnt",  128'(wr_cnt[0]),     128'd2);
    check("f32_addr0",   128'(wr_addr[0][0]), 128'd0);
    check("f32_data0",   wr_data[0][0],       128'h0F0E0D0C0B0A09080706050403020100);
    check("f32_wea0",    128'(wr_wea[0][0]),  128'hFFFF);
    check("f32_lat0",    128'(wr_cyc[0][0]),  128'(acc16));
    check("f32_addr1",   128'(wr_addr[0][1]), 128'd1);
    check("f32_data1",   wr_data[0][1],       128'h1F1E1D1C1B1A19181716151413121110);
    check("f32_wea1",    128'(wr_wea[0][1]),  128'hFFFF);
    check("f32_lat1",    128'(wr_cyc[0][1]),  128'(last_acc));
    check("f32_done_n",  128'(done_cnt[0]),   128'd1);
    check("f32_done_at", 128'(done_cyc[0]),   128'(wr_cyc[0][1] + 1));
    check("f32_busy_dn", 128'(busy_at_done[0]), 128'h0);
    check("f32_drop",    128'(drop[0]),       128'h0);

    // 20 bytes: one full word then a 4-lane flush
    do_reset();
    start();
    for (int k = 0; k < 20; k++) send_byte(8'hA0 + 8'(k));
    wait_done(1);
    check("f20_wr_cnt", 128'(wr_cnt[1]),     128'd2);
    check("f20_addr0",  128'(wr_addr[1][0]), 128'd0);
    check("f20_data0",  wr_data[1][0],       128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    check("f20_addr1",  128'(wr_addr[1][1]), 128'd1);
    check("f20_ena1",   128'(wr_ena[1][1]),  128'hFFFF);
    check("f20_wea1",   128'(wr_wea[1][1]),  128'h000F);
    check("f20_data1",  wr_data[1][1],       128'h000000000000000000000000B3B2B1B0);
    check("f20_flat",   128'(wr_cyc[1][1]),  128'(last_acc + 1));
    check("f20_done_at", 128'(done_cyc[1]),  128'(wr_cyc[1][1] + 1));

    // 16 bytes with iVld on alternate cycles
    do_reset();
    start();
    for (int k = 0; k < 16; k++) begin
      send_byte(8'h50 + 8'(k));
      if (k != 15) tick();
    end
    acc16 = last_acc;
    wait_done(2);
    check("gap_wr_cnt", 128'(wr_cnt[2]),     128'd1);
    check("gap_lat",    128'(wr_cyc[2][0]),  128'(acc16));
    check("gap_data",   wr_data[2][0],       128'h5F5E5D5C5B5A59585756555453525150);
    check("gap_done_n", 128'(done_cnt[2]),   128'd1);

    // Drops: byte before start, byte alongside start, three after frame end
    do_reset();
    send_byte(8'hEE);
    check("drop_pre", 128'(drop[2]), 128'h1);
    do_reset();
    check("drop_rst", 128'(drop[2]), 128'h0);
    iVld = 1'b1; iData = 8'hDD; iStart = 1'b1;
    tick();
    iVld = 1'b0; iStart = 1'b0;
    check("drop_start", 128'(drop[2]), 128'h1);
    for (int k = 0; k < 16; k++) send_byte(8'h30 + 8'(k));
    for (int k = 0; k < 3; k++) send_byte(8'hC0 + 8'(k));
    wait_done(2);
    check("drop_wr_cnt", 128'(wr_cnt[2]),   128'd1);
    check("drop_data",   wr_data[2][0],     128'h3F3E3D3C3B3A39383736353433323130);
    check("drop_sticky", 128'(drop[2]),     128'h1);

    // Reset mid-frame, then a clean frame
    do_reset();
    start();
    for (int k = 0; k < 10; k++) send_byte(8'h90 + 8'(k));
    rstn = 1'b1;
    tick();
    rstn = 1'b0;
    repeat (4) tick();
    check("abort_wr_cnt", 128'(wr_cnt[2]), 128'd0);
    check("abort_busy",   128'(busy[2]),   128'h0);
    start();
    for (int k = 0; k < 16; k++) send_byte(8'h60 + 8'(k));
    wait_done(2);
    check("abort_new_cnt",  128'(wr_cnt[2]),     128'd1);
    check("abort_new_addr", 128'(wr_addr[2][0]), 128'd0);
    check("abort_new_data", wr_data[2][0],       128'h6F6E6D6C6B6A69686766656463626160);

    // Address wrap from BASE_ADDR=510
    do_reset();
    start();
    for (int k = 0; k < 48; k++) send_byte(8'(k));
    wait_done(3);
    check("wrap_wr_cnt", 128'(wr_cnt[3]),     128'd3);
    check("wrap_addr0",  128'(wr_addr[3][0]), 128'd510);
    check("wrap_addr1",  128'(wr_addr[3][1]), 128'd511);
    check("wrap_addr2",  128'(wr_addr[3][2]), 128'd0);
    check("wrap_data2",  wr_data[3][2],       128'h2F2E2D2C2B2A29282726252423222120);
    check("wrap_done_n", 128'(done_cnt[3]),   128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
